// File: rtl/commit_scheduler.sv
// commit_scheduler
//   Retires the head entry of the commit ring in order. The head entry's type
//   selects the resource the commit waits on:
//     COMMIT_GPR    (2'd0) : waits for the ALU result, then writes the register file
//     COMMIT_GPR_IN (2'd1) : waits for a receiver byte, then writes the register file
//     COMMIT_OUT    (2'd2) : requests the transmitter and waits for it to accept
//     2'd3                 : illegal; sets the sticky error flag
//   GPR and GPR_IN commits share one registered register-file write stage.
//   This block also handles run/halt/single-step control and keeps the debug
//   counters.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   head_valid/type/dst   head entry of the commit ring
//   head_pop              head retired this cycle
//   gpr_result_valid/...  ALU result for the head entry
//   in_valid/data/ack     receiver byte interface
//   out_valid/ready/data  transmitter request (out_data = gpr_result[7:0])
//   rf_we/waddr/wdata     registered register-file write port
//   run, step, halted     debug run control
//   error                 sticky illegal-type flag
//   retired_count         wrapping count of retirements
//   stall_count           saturating count of cycles where head_valid=1 and head_pop=0
//
// Handshakes: a transfer happens in the cycle where valid and ready (or
// ack/pop) are both high. head_pop, in_ack and out_valid are combinational
// from the current inputs and state.
module commit_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      head_valid,
  input  logic [1:0]                head_type,
  input  logic [REG_ADDR_WIDTH-1:0] head_dst,
  output logic                      head_pop,
  input  logic                      gpr_result_valid,
  input  logic [DATA_WIDTH-1:0]     gpr_result,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic                      run,
  input  logic                      step,
  output logic                      halted,
  output logic                      error,
  output logic [CNT_WIDTH-1:0]      retired_count,
  output logic [15:0]               stall_count
);

  localparam logic [1:0] COMMIT_GPR    = 2'd0;
  localparam logic [1:0] COMMIT_GPR_IN = 2'd1;
  localparam logic [1:0] COMMIT_OUT    = 2'd2;

  logic                      step_credit_q, step_credit_d;
  logic                      error_q, error_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic [CNT_WIDTH-1:0]      retired_q, retired_d;
  logic [15:0]               stall_q, stall_d;

  logic commit_en;
  logic active;
  logic illegal;
  logic wr_load;
  logic [DATA_WIDTH-1:0] wr_data;

  assign commit_en = !error_q && (run || step_credit_q);
  assign active    = head_valid && commit_en;

  // Retire decision for the current head.
  always_comb begin
    head_pop  = 1'b0;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    illegal   = 1'b0;
    wr_load   = 1'b0;
    wr_data   = gpr_result;
    if (active) begin
      case (head_type)
        COMMIT_GPR: begin
          if (gpr_result_valid) begin
            head_pop = 1'b1;
            wr_load  = 1'b1;
          end
        end
        COMMIT_GPR_IN: begin
          if (in_valid) begin
            head_pop = 1'b1;
            in_ack   = 1'b1;
            wr_load  = 1'b1;
            wr_data  = DATA_WIDTH'(in_data);
          end
        end
        COMMIT_OUT: begin
          out_valid = 1'b1;
          head_pop  = out_ready;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    // A pop that used the credit clears it. A step that arrives while the
    // credit is already set is dropped, so steps do not queue.
    step_credit_d = step_credit_q;
    if (head_pop && step_credit_q)
      step_credit_d = 1'b0;
    else if (step && !step_credit_q)
      step_credit_d = 1'b1;

    error_d = error_q || illegal;

    // Address and data only change on a write. rf_we alone says whether
    // a write is happening.
    rf_we_d    = wr_load;
    rf_waddr_d = wr_load ? head_dst : rf_waddr_q;
    rf_wdata_d = wr_load ? wr_data  : rf_wdata_q;

    retired_d = head_pop ? retired_q + 1'b1 : retired_q;

    stall_d = stall_q;
    if (head_valid && !head_pop && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_credit_q <= 1'b0;
      error_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      retired_q     <= '0;
      stall_q       <= '0;
    end else begin
      step_credit_q <= step_credit_d;
      error_q       <= error_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      retired_q     <= retired_d;
      stall_q       <= stall_d;
    end
  end

  assign out_data      = gpr_result[7:0];
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign halted        = !run && !step_credit_q;
  assign error         = error_q;
  assign retired_count = retired_q;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_commit_scheduler.sv
module tb_commit_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;

  localparam logic [1:0] T_GPR    = 2'd0;
  localparam logic [1:0] T_GPR_IN = 2'd1;
  localparam logic [1:0] T_OUT    = 2'd2;
  localparam logic [1:0] T_BAD    = 2'd3;

  logic          clk;
  logic          reset;
  logic          head_valid;
  logic [1:0]    head_type;
  logic [AW-1:0] head_dst;
  logic          head_pop;
  logic          gpr_result_valid;
  logic [DW-1:0] gpr_result;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ack;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          run;
  logic          step;
  logic          halted;
  logic          error;
  logic [CW-1:0] retired_count;
  logic [15:0]   stall_count;

  int checks = 0;
  int errors = 0;

  // Expected register-file writes as {addr, data}, in retirement order.
  logic [AW+DW-1:0] exp_q[$];
  logic [CW-1:0]    exp_retired = '0;
  logic [15:0]      exp_stall   = '0;

  commit_scheduler #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .head_valid(head_valid), .head_type(head_type), .head_dst(head_dst),
    .head_pop(head_pop),
    .gpr_result_valid(gpr_result_valid), .gpr_result(gpr_result),
    .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .run(run), .step(step), .halted(halted), .error(error),
    .retired_count(retired_count), .stall_count(stall_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every observed register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=0x%08h, expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=0x%08h, expected addr=%0d data=0x%08h",
                   rf_waddr, rf_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_idle();
    head_valid = 1'b0; head_type = T_GPR; head_dst = '0;
    gpr_result_valid = 1'b0; gpr_result = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; step = 1'b0;
  endtask

  task automatic drive_head(input logic [1:0] t, input logic [AW-1:0] d);
    head_valid = 1'b1; head_type = t; head_dst = d;
  endtask

  task automatic test_reset();
    drive_idle();
    run = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", head_pop); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack: got %b expected 0", in_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== '0) begin errors++; $display("FAIL reset_rf: got we=%b addr=%0d data=0x%08h expected all 0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", halted); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (retired_count !== '0 || stall_count !== '0) begin errors++; $display("FAIL reset_counters: got retired=%0d stall=%0d expected 0 0", retired_count, stall_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_head(T_GPR, AW'(i + 1));
      gpr_result_valid = 1'b1; gpr_result = vals[i];
      #1;
      checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop[%0d]: got %b expected 1", i, head_pop); end
      exp_q.push_back({AW'(i + 1), vals[i]});
      exp_retired++;
      // Write from the previous pop must already be visible on this cycle.
      if (i > 0) begin
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b2b_rf_we[%0d]: got %b expected 1", i, rf_we); end
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b2b_rf_we_last: got %b expected 1", rf_we); end
    checks++; if (retired_count !== exp_retired) begin errors++; $display("FAIL b2b_retired: got %0d expected %0d", retired_count, exp_retired); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_rf_drain: got %b expected 0", rf_we); end
  endtask

  task automatic test_gpr_in();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_head(T_GPR_IN, 5'd9);
      in_valid = (i == 4); in_data = 8'h5A;
      #1;
      checks++;
      if (head_pop !== in_valid || in_ack !== in_valid) begin
        errors++; $display("FAIL gpr_in_pop[%0d]: got pop=%b ack=%b expected %b", i, head_pop, in_ack, in_valid);
      end
      if (in_valid) begin
        exp_q.push_back({5'd9, 32'h0000005A});
        exp_retired++;
      end else begin
        exp_stall++;
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL gpr_in_stall: got %0d expected %0d", stall_count, exp_stall); end
    checks++; if (rf_wdata !== 32'h0000005A) begin errors++; $display("FAIL gpr_in_wdata: got 0x%08h expected 0x0000005a", rf_wdata); end
  endtask

  task automatic test_out();
    // out_ready is ignored when no OUT commit is waiting.
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
    #1;
    checks++; if (head_pop !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL out_idle_ready: got pop=%b out_valid=%b expected 0 0", head_pop, out_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_head(T_OUT, 5'd4);
      gpr_result = 32'h000001C3;
      out_ready = (i == 3);
      #1;
      checks++;
      if (out_valid !== 1'b1 || head_pop !== out_ready || out_data !== 8'hC3) begin
        errors++; $display("FAIL out_cycle[%0d]: got out_valid=%b pop=%b data=0x%02h expected 1 %b 0xc3", i, out_valid, head_pop, out_data, out_ready);
      end
      if (out_ready) exp_retired++; else exp_stall++;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL out_no_write: got rf_we=%b expected 0", rf_we); end
    checks++; if (retired_count !== exp_retired || stall_count !== exp_stall) begin errors++; $display("FAIL out_counters: got retired=%0d stall=%0d expected %0d %0d", retired_count, stall_count, exp_retired, exp_stall); end
  endtask

  task automatic test_step();
    logic [DW-1:0] d0, d1;
    d0 = DW'($urandom_range(0, 32'h7FFFFFFF));
    d1 = DW'($urandom_range(0, 32'h7FFFFFFF));
    run = 1'b0;
    for (int e = 0; e < 2; e++) begin
      // Halted: eligible head waits.
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        drive_head(T_GPR, AW'(7 + e));
        gpr_result_valid = 1'b1; gpr_result = (e == 0) ? d0 : d1;
        step = 1'b0;
        #1;
        checks++; if (head_pop !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL step_halted[%0d.%0d]: got pop=%b halted=%b expected 0 1", e, i, head_pop, halted); end
        exp_stall++;
      end
      // Step pulse: credit only takes effect from the next cycle.
      @(negedge clk);
      step = 1'b1;
      #1;
      checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL step_pulse_pop[%0d]: got %b expected 0", e, head_pop); end
      exp_stall++;
      @(negedge clk);
      step = 1'b0;
      #1;
      checks++; if (head_pop !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL step_pop[%0d]: got pop=%b halted=%b expected 1 0", e, head_pop, halted); end
      exp_q.push_back({AW'(7 + e), (e == 0) ? d0 : d1});
      exp_retired++;
    end
    @(negedge clk);
    drive_head(T_GPR, 5'd9);
    gpr_result_valid = 1'b1;
    #1;
    checks++; if (head_pop !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL step_rehalt: got pop=%b halted=%b expected 0 1", head_pop, halted); end
    exp_stall++;
    @(negedge clk);
    drive_idle();
    run = 1'b1;
    #1;
    checks++; if (retired_count !== exp_retired || stall_count !== exp_stall) begin errors++; $display("FAIL step_counters: got retired=%0d stall=%0d expected %0d %0d", retired_count, stall_count, exp_retired, exp_stall); end
  endtask

  task automatic test_random();
    logic exp_pop;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      head_valid       = 1'($urandom_range(0, 3) != 0);
      head_type        = 2'($urandom_range(0, 2));
      head_dst         = AW'($urandom_range(0, 31));
      gpr_result_valid = 1'($urandom_range(0, 1));
      gpr_result       = DW'($urandom());
      in_valid         = 1'($urandom_range(0, 1));
      in_data          = 8'($urandom_range(0, 255));
      out_ready        = 1'($urandom_range(0, 1));
      case (head_type)
        T_GPR:    exp_pop = head_valid && gpr_result_valid;
        T_GPR_IN: exp_pop = head_valid && in_valid;
        default:  exp_pop = head_valid && out_ready;
      endcase
      #1;
      checks++;
      if (head_pop !== exp_pop || in_ack !== (exp_pop && head_type == T_GPR_IN) ||
          out_valid !== (head_valid && head_type == T_OUT)) begin
        errors++; $display("FAIL random[%0d]: got pop=%b ack=%b ov=%b expected pop=%b type=%0d", i, head_pop, in_ack, out_valid, exp_pop, head_type);
      end
      if (exp_pop) begin
        exp_retired++;
        if (head_type == T_GPR)    exp_q.push_back({head_dst, gpr_result});
        if (head_type == T_GPR_IN) exp_q.push_back({head_dst, DW'(in_data)});
      end else if (head_valid) begin
        exp_stall++;
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (retired_count !== exp_retired || stall_count !== exp_stall) begin errors++; $display("FAIL random_counters: got retired=%0d stall=%0d expected %0d %0d", retired_count, stall_count, exp_retired, exp_stall); end
  endtask

  task automatic test_illegal();
    run = 1'b1;
    @(negedge clk);
    drive_head(T_BAD, 5'd1);
    #1;
    checks++; if (head_pop !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL illegal_first: got pop=%b error=%b expected 0 0", head_pop, error); end
    exp_stall++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_head(T_GPR, 5'd2);
      gpr_result_valid = 1'b1;
      #1;
      checks++; if (head_pop !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL illegal_blocked[%0d]: got pop=%b error=%b expected 0 1", i, head_pop, error); end
      exp_stall++;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (error !== 1'b1 || stall_count !== exp_stall || retired_count !== exp_retired) begin errors++; $display("FAIL illegal_after: got error=%b stall=%0d retired=%0d expected 1 %0d %0d", error, stall_count, retired_count, exp_stall, exp_retired); end
  endtask

  task automatic test_reset_mid();
    // Asynchronous clear of the sticky error, between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (error !== 1'b0 || retired_count !== '0 || stall_count !== '0) begin errors++; $display("FAIL reset_async: got error=%b retired=%0d stall=%0d expected 0 0 0", error, retired_count, stall_count); end
    @(negedge clk);
    reset = 1'b0;
    // One pop whose write is dropped by reset before it is observed.
    @(negedge clk);
    drive_head(T_GPR, 5'd3);
    gpr_result_valid = 1'b1; gpr_result = 32'hDEAD_BEEF;
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL reset_mid_pop: got %b expected 1", head_pop); end
    @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL reset_mid_pending: got rf_we=%b expected 1", rf_we); end
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || retired_count !== '0) begin errors++; $display("FAIL reset_mid_clear: got rf_we=%b retired=%0d expected 0 0", rf_we, retired_count); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    run = 1'b0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_back_to_back();
    test_gpr_in();
    test_out();
    test_step();
    test_random();
    test_illegal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
